rc4_ksa_shuffle: RTL

Parametrised RC4 key-scheduling shuffle engine: a self-sequencing controller plus datapath.
- For i = 0..2^ADDR_W-1: j = j + S[i] + key[i mod KEY_BYTES]; then swap S[i] and S[j].
- Drives a single-port synchronous S-memory (already initialised S[k]=k by the upstream init block).
- Sits between the init stage and the decrypt stage in the RC4 top-level FSM chain.
- Generalises the earlier flag-driven shuffle datapath: its sequencing is internal, key length and memory geometry are parametrised, read latency is configurable, and it has a start/busy/done handshake.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_key_mux.sv | 21 ++
 rtl/rc4_ksa_shuffle.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling shuffle engine.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    DONE
  } state_e;

  localparam int KEY_BYTES_DEF = 3;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_KEY_BYTES = 32;

  // Byte idx of an nbytes-long key, byte 0 being the most significant.
  function automatic logic [7:0] key_byte(input logic [MAX_KEY_BYTES*8-1:0] key,
                                          input int unsigned nbytes,
                                          input int unsigned idx);
    logic [MAX_KEY_BYTES*8-1:0] shifted;
    shifted = key >> ((nbytes - 1 - idx) * 8);
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/rc4_key_mux.sv
// Combinational key byte selector driven by the wrapping key-index counter.
module rc4_key_mux
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int KIDX_W    = 2
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [KIDX_W-1:0]      idx,
  output logic [7:0]             key_byte_o
);

  logic [MAX_KEY_BYTES*8-1:0] key_ext;

  always_comb begin
    key_ext                  = '0;
    key_ext[KEY_BYTES*8-1:0] = key;
    key_byte_o               = key_byte(key_ext, KEY_BYTES, 32'(idx));
  end

endmodule

// File: rtl/rc4_ksa_shuffle.sv
// RC4 key-scheduling shuffle: walks i over the S-memory, accumulates j and
// swaps S[i]/S[j] through a single-port synchronous memory.
module rc4_ksa_shuffle
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_wr_en,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic                   done
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int SUM_W  = ((DATA_W > 8) ? DATA_W : 8) + 2;
  localparam logic [ADDR_W-1:0] I_LAST    = '1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [ADDR_W-1:0]      si_q, si_d;
  logic [DATA_W-1:0]      sj_q, sj_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [1:0]             wcnt_q, wcnt_d;

  logic [7:0]             kbyte;
  logic [SUM_W-1:0]       j_sum;

  rc4_key_mux #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_mux (
    .key        (key_q),
    .idx        (kidx_q),
    .key_byte_o (kbyte)
  );

  // Wide enough that the three-term sum never overflows before the modulo.
  assign j_sum = SUM_W'(j_q) + SUM_W'(mem_rdata) + SUM_W'(kbyte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      kidx_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    key_d     = key_q;
    kidx_d    = kidx_q;
    wcnt_d    = wcnt_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = READ_I;
        end
      end
      READ_I: begin
        mem_addr = i_q;
        wcnt_d   = '0;
        state_d  = WAIT_I;
      end
      WAIT_I: begin
        mem_addr = i_q;
        if (wcnt_q == WAIT_LAST) begin
          si_d    = mem_rdata[ADDR_W-1:0];
          j_d     = j_sum[ADDR_W-1:0];
          state_d = READ_J;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      READ_J: begin
        mem_addr = j_q;
        wcnt_d   = '0;
        state_d  = WAIT_J;
      end
      WAIT_J: begin
        mem_addr = j_q;
        if (wcnt_q == WAIT_LAST) begin
          sj_d    = mem_rdata;
          state_d = WRITE_I;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      WRITE_I: begin
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wr_en = 1'b1;
        state_d   = WRITE_J;
      end
      WRITE_J: begin
        mem_addr  = j_q;
        mem_wdata = DATA_W'(si_q);
        mem_wr_en = 1'b1;
        // The last index is detected before incrementing, so i never overflows.
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
          state_d = READ_I;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
